simon_serial_core: RTL
======================

# simon_serial_core

Parametrised SIMON block-cipher encryption core that replaces the fixed-key bit-serial top level. Plaintext and key are loaded over a DIN_W-bit serial stream. The key is held in a persistent store so successive blocks can reuse it. One round executes per cycle, and the ciphertext streams back out DIN_W bits per cycle. The core sits between the chip I/O shift interface and the debug/readout logic.

## Interface
- WORD_W, 16: SIMON word size n; block is 2·WORD_W bits; legal values 16, 24, 32.
- KEY_WORDS, 4: key words m; legal values 2, 3, 4.
- ROUNDS, 32: round count T; must match the (n, m) pair.
- DIN_W, 1: serial beat width; must divide WORD_W.
- Z_SEQ, z0: 62-bit constant sequence from simon_pkg.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  DIN_W  load data, MSB-first.
- din_valid  in  1  load strobe for din.
- din_sel  in  1  load target: 0 = plaintext register, 1 = key store.
- start  in  1  begin encryption (IDLE only).
- busy  out  1  high in RUN and UNLOAD.
- dout  out  DIN_W  ciphertext beat, MSB-first.
- dout_valid  out  1  dout qualifier.
- done  out  1  one-cycle pulse on the last dout beat.
- debug_port  in  1  present only with SIMON_KEY_READBACK_EN.

## Operation
- FSM states: IDLE → RUN → UNLOAD → IDLE.
- IDLE load behaviour:
  - Each din_valid shifts din into the LSBs of the register chosen by din_sel; existing contents shift left by DIN_W.
  - Plaintext register is {x, y}, 2·WORD_W bits.
  - Key store is {k[m-1], …, k[0]}, m·WORD_W bits.
  - Loads are unchecked: the last 2n (or mn) bits shifted in win.
- IDLE, start=1:
  - Copy the key store into the working key register.
  - Clear the round counter to 0 and enter RUN.
  - start takes priority over a same-cycle din_valid; that din beat is dropped.
- RUN, once per cycle:
  - Data update: x' = y ^ f(x) ^ k[0], y' = x, where f(x) = (S¹x & S⁸x) ^ S²x.
  - Key update: the working key register shifts down one word; the new top word is c ^ z[i mod 62] ^ k[0] ^ tmp ^ S⁻¹tmp, with c = 2ⁿ−4.
  - tmp = S⁻³k[m-1], then ^ k[1] when m = 4.
  - Round counter increments each round. After the round with counter = ROUNDS−1, enter UNLOAD.
- UNLOAD:
  - Emits 2·WORD_W/DIN_W beats of {x, y}, MSB-first, with dout_valid high on each.
  - done is high on the final beat, after which the FSM returns to IDLE.
- Key store is never modified by RUN; the plaintext register holds ciphertext after a run.
- start, din_valid, and debug_port are ignored outside IDLE.
- No backpressure on dout.

## Timing
- Reset (asynchronous): all registers zero, including the key store; FSM in IDLE; busy, dout, dout_valid, and done all 0.
- Reset mid-run aborts immediately. No partial ciphertext is emitted.
- start sampled at edge E0:
  - busy=1 after E0.
  - Rounds execute at edges E1 through E_T.
  - First dout beat is valid after E_T.
  - Last beat is valid after E_(T+2n/DIN_W−1); busy falls after the following edge.
- Total latency from start to done: T + 2n/DIN_W cycles.
- A new start is accepted on the first IDLE cycle after done.

## Configuration
- SIMON_KEY_READBACK_EN defined:
  - The debug_port input exists and is sampled with start.
  - If debug_port was 1, UNLOAD streams {k_(T-2), k_(T-1)} (the last two round keys used) instead of ciphertext; beat count, done, and data-register contents are unchanged.
- SIMON_KEY_READBACK_EN undefined: no debug_port, no readback mux, and no retained round-key flops. Only ciphertext is ever output.

## Structure
- simon_pkg:
  - z0–z4 62-bit constants.
  - FSM state enum.
  - Function computing c for WORD_W.
  - Legal (n, m, T) table used by elaboration-time checks.
- One sub-module, simon_key_schedule: working key register, key update, z-index counter, and load-from-store on start. The core holds the data path, FSM, load/unload shifters, and counters.

## Test plan
- Known-answer, default parameters, DIN_W=1:
  - Stimulus: load key 1918_1110_0908_0100, load plaintext 6565_6877, start.
  - Response: dout streams c69b_e9bb MSB-first over 32 beats; done on beat 32; start-to-done latency 64 cycles.
- Key reuse:
  - Stimulus: after the known-answer run, reload plaintext 6565_6877 only and start.
  - Response: same ciphertext c69b_e9bb.
- start with same-cycle din_valid:
  - Stimulus: assert start and din_valid (din_sel=0) together; also pulse start and din_valid repeatedly during RUN.
  - Response: the same-cycle din beat is dropped; the RUN pulses are ignored; the ciphertext is unchanged.
- Reset mid-run:
  - Stimulus: assert reset at round 10.
  - Response: all outputs 0 immediately; no dout_valid; key store cleared, so a following run with no reload uses the all-zero key and matches the model.
- DIN_W=4:
  - Stimulus: known-answer vector with DIN_W=4.
  - Response: 8 beats, dout nibbles c, 6, 9, b, e, 9, b, b.
- Readback (macro on):
  - Stimulus: known-answer vector with debug_port=1 at start.
  - Response: dout matches the model's k_30, k_31; a following run with debug_port=0 outputs c69b_e9bb.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared SIMON constants, FSM state type and parameter helpers for simon_serial_core.
package simon_pkg;

  // Bit 61 is z_0 (first symbol of the published sequence), bit 0 is z_61.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  // c = 2^n - 4, returned right-aligned in 32 bits
  function automatic logic [31:0] simon_const(input int n);
    return (32'hFFFF_FFFF >> (32 - n)) & ~32'h3;
  endfunction

  function automatic bit simon_legal(input int n, input int m, input int t);
    return (n == 16 && m == 4 && t == 32) ||
           (n == 24 && m == 3 && t == 36) ||
           (n == 24 && m == 4 && t == 36) ||
           (n == 32 && m == 3 && t == 42) ||
           (n == 32 && m == 4 && t == 44);
  endfunction

endpackage

// File: rtl/simon_key_schedule.sv
// SIMON working key register: loads from the key store on start, then produces one
// round key per step and rolls the schedule forward.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int          WORD_W    = 16,
  parameter int          KEY_WORDS = 4,
  parameter logic [61:0] Z_SEQ     = Z0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          step,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_store,
  output logic [WORD_W-1:0]             k0
);

  localparam int KEY_W = KEY_WORDS * WORD_W;

  logic [KEY_W-1:0]  key_q;
  logic [5:0]        z_idx;
  logic [5:0]        z_pos;
  logic [WORD_W-1:0] k_top, k_one, tmp, c_word, new_word;

  always_comb begin
    k_top  = key_q[KEY_W-1 -: WORD_W];
    k_one  = key_q[2*WORD_W-1 -: WORD_W];
    c_word = WORD_W'(simon_const(WORD_W));
    z_pos  = 6'd61 - z_idx;
    tmp    = {k_top[2:0], k_top[WORD_W-1:3]};
    if (KEY_WORDS == 4) tmp = tmp ^ k_one;
    new_word = c_word ^ tmp ^ {tmp[0], tmp[WORD_W-1:1]} ^ key_q[WORD_W-1:0]
             ^ {{(WORD_W-1){1'b0}}, Z_SEQ[z_pos]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '0;
      z_idx <= '0;
    end else if (load) begin
      key_q <= key_store;
      z_idx <= '0;
    end else if (step) begin
      key_q <= {new_word, key_q[KEY_W-1:WORD_W]};
      z_idx <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
    end
  end

  assign k0 = key_q[WORD_W-1:0];

endmodule

// File: rtl/simon_serial_core.sv
// Bit-serial-loaded SIMON encryption core with persistent key store.
// Optional SIMON_KEY_READBACK_EN adds debug_port and last-two-round-key readback.
//   state     | meaning
//   ST_IDLE   | accept din loads into plaintext/key store, wait for start
//   ST_RUN    | one round per cycle, ROUNDS cycles
//   ST_UNLOAD | stream {x, y} (or round keys) out DIN_W bits per cycle
module simon_serial_core
  import simon_pkg::*;
#(
  parameter int          WORD_W    = 16,
  parameter int          KEY_WORDS = 4,
  parameter int          ROUNDS    = 32,
  parameter int          DIN_W     = 1,
  parameter logic [61:0] Z_SEQ     = Z0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_sel,
  input  logic             start,
`ifdef SIMON_KEY_READBACK_EN
  input  logic             debug_port,
`endif
  output logic             busy,
  output logic [DIN_W-1:0] dout,
  output logic             dout_valid,
  output logic             done
);

  localparam int BLK_W  = 2 * WORD_W;
  localparam int KEY_W  = KEY_WORDS * WORD_W;
  localparam int BEATS  = BLK_W / DIN_W;
  localparam int RND_W  = $clog2(ROUNDS);
  localparam int BEAT_W = $clog2(BEATS);

  if (!simon_legal(WORD_W, KEY_WORDS, ROUNDS)) begin : g_bad_params
    $error("simon_serial_core: illegal (WORD_W, KEY_WORDS, ROUNDS) combination");
  end
  if (WORD_W % DIN_W != 0) begin : g_bad_din_w
    $error("simon_serial_core: DIN_W must divide WORD_W");
  end

  state_t            state;
  logic [BLK_W-1:0]  pt_q;
  logic [KEY_W-1:0]  key_store_q;
  logic [RND_W-1:0]  rnd_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BLK_W-1:0]  out_sr;
  logic [WORD_W-1:0] k0, x, y, fx, x_nxt;
  logic [BLK_W-1:0]  blk_nxt, unload_blk;

`ifdef SIMON_KEY_READBACK_EN
  logic              dbg_q;
  logic [WORD_W-1:0] rk_last;
`endif

  simon_key_schedule #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS),
    .Z_SEQ     (Z_SEQ)
  ) u_key_schedule (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_IDLE && start),
    .step      (state == ST_RUN),
    .key_store (key_store_q),
    .k0        (k0)
  );

  always_comb begin
    x     = pt_q[BLK_W-1 -: WORD_W];
    y     = pt_q[WORD_W-1:0];
    fx    = ({x[WORD_W-2:0], x[WORD_W-1]} & {x[WORD_W-9:0], x[WORD_W-1:WORD_W-8]})
          ^ {x[WORD_W-3:0], x[WORD_W-1:WORD_W-2]};
    x_nxt   = y ^ fx ^ k0;
    blk_nxt = {x_nxt, x};
`ifdef SIMON_KEY_READBACK_EN
    // k0 is the final round's key here; rk_last holds the one before it
    unload_blk = dbg_q ? {rk_last, k0} : blk_nxt;
`else
    unload_blk = blk_nxt;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pt_q        <= '0;
      key_store_q <= '0;
      rnd_q       <= '0;
      beat_q      <= '0;
      out_sr      <= '0;
      busy        <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      done        <= 1'b0;
`ifdef SIMON_KEY_READBACK_EN
      dbg_q       <= 1'b0;
      rk_last     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rnd_q <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
`ifdef SIMON_KEY_READBACK_EN
            dbg_q <= debug_port;
`endif
          end else if (din_valid) begin
            if (din_sel) key_store_q <= {key_store_q[KEY_W-DIN_W-1:0], din};
            else         pt_q        <= {pt_q[BLK_W-DIN_W-1:0], din};
          end
        end
        ST_RUN: begin
          pt_q  <= blk_nxt;
          rnd_q <= rnd_q + 1'b1;
`ifdef SIMON_KEY_READBACK_EN
          rk_last <= k0;
`endif
          if (rnd_q == RND_W'(ROUNDS - 1)) begin
            state      <= ST_UNLOAD;
            dout       <= unload_blk[BLK_W-1 -: DIN_W];
            out_sr     <= unload_blk << DIN_W;
            dout_valid <= 1'b1;
            beat_q     <= '0;
          end
        end
        ST_UNLOAD: begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
          end else begin
            dout   <= out_sr[BLK_W-1 -: DIN_W];
            out_sr <= out_sr << DIN_W;
            beat_q <= beat_q + 1'b1;
            done   <= (beat_q == BEAT_W'(BEATS - 2));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
